// File: rtl/lfsr_rng_arbiter.sv
//------------------------------------------------------------------------------
// Module   : lfsr_rng_arbiter
// Brief    : Round-robin shared 4-bit XNOR LFSR with per-requester rejection
//            sampling below a latched limit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lfsr_rng_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [4*NUM_REQ-1:0]   limit,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   valid,
    output logic [3:0]             random_out,
    output logic                   busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state,  w_state_nxt;
    logic [3:0]           r_lfsr,   w_lfsr_nxt;
    logic [IW-1:0]        r_ptr,    w_ptr_nxt;
    logic [IW-1:0]        r_idx,    w_idx_nxt;
    logic [3:0]           r_limit,  w_limit_nxt;
    logic [NUM_REQ-1:0]   r_gnt,    w_gnt_nxt;
    logic                 r_valid,  w_valid_nxt;
    logic [3:0]           r_random, w_random_nxt;
    logic                 r_busy,   w_busy_nxt;

    logic                 w_found;
    logic [IW-1:0]        w_pick;
    logic [3:0]           w_pick_lim;
    logic [NUM_REQ-1:0]   w_pick_oh;
    logic [IW-1:0]        w_ptr_inc;
    logic [4:0]           w_eff;
    logic                 w_accept;
    int                   w_j;

    // Walk the search order backwards so the last hit is the first set bit
    // at or after the pointer.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_j     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_j = int'(r_ptr) + k;
            if (w_j >= NUM_REQ) begin
                w_j = w_j - NUM_REQ;
            end
            if (req[IW'(w_j)]) begin
                w_found = 1'b1;
                w_pick  = IW'(w_j);
            end
        end
    end

    always_comb begin
        w_pick_lim = 4'h0;
        w_pick_oh  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick == IW'(i)) begin
                w_pick_lim   = limit[4*i +: 4];
                w_pick_oh[i] = 1'b1;
            end
        end
    end

    assign w_ptr_inc = (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
    // A zero limit means the full 16-value range, so every sample is accepted.
    assign w_eff     = (r_limit == 4'h0) ? 5'd16 : {1'b0, r_limit};
    assign w_accept  = ({1'b0, r_lfsr} < w_eff);

    always_comb begin
        w_state_nxt  = r_state;
        w_lfsr_nxt   = {r_lfsr[2:0], ~(r_lfsr[3] ^ r_lfsr[2])};
        w_ptr_nxt    = r_ptr;
        w_idx_nxt    = r_idx;
        w_limit_nxt  = r_limit;
        w_gnt_nxt    = r_gnt;
        w_valid_nxt  = r_valid;
        w_random_nxt = r_random;
        w_busy_nxt   = r_busy;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_idx_nxt   = w_pick;
                    w_limit_nxt = w_pick_lim;
                    w_gnt_nxt   = w_pick_oh;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_SERVE;
                end
            end
            S_SERVE: begin
                if (w_accept) begin
                    w_random_nxt = r_lfsr;
                    w_valid_nxt  = 1'b1;
                    w_state_nxt  = S_DONE;
                end
            end
            S_DONE: begin
                w_valid_nxt = 1'b0;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
                w_ptr_nxt   = w_ptr_inc;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_lfsr   <= 4'h0;
            r_ptr    <= '0;
            r_idx    <= '0;
            r_limit  <= 4'h0;
            r_gnt    <= '0;
            r_valid  <= 1'b0;
            r_random <= 4'h0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_lfsr   <= w_lfsr_nxt;
            r_ptr    <= w_ptr_nxt;
            r_idx    <= w_idx_nxt;
            r_limit  <= w_limit_nxt;
            r_gnt    <= w_gnt_nxt;
            r_valid  <= w_valid_nxt;
            r_random <= w_random_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign gnt        = r_gnt;
    assign valid      = r_valid;
    assign random_out = r_random;
    assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_rng_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_lfsr_rng_arbiter
// Brief    : Self-checking bench; predicts grants and returned values from the
//            known LFSR sequence and the round-robin rule.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lfsr_rng_arbiter;

    localparam int N = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req   = '0;
    logic [4*N-1:0]   limit = '0;
    logic [N-1:0]     gnt;
    logic             valid;
    logic [3:0]       random_out;
    logic             busy;

    lfsr_rng_arbiter #(.NUM_REQ(N)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .limit      (limit),
        .gnt        (gnt),
        .valid      (valid),
        .random_out (random_out),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // LFSR output after k edges from reset is seq[k mod 15].
    logic [3:0] seq [$] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
                            4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};

    int         checks   = 0;
    int         failures = 0;
    int         n        = 0;
    int         mptr     = 0;
    logic [3:0] exp_rand = 4'h0;
    logic [3:0] lim_m [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) begin
            if (k == i) v = v | (N'(1) << k);
        end
        return v;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if ((r & onehot((p + k) % N)) != '0) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_limits();
        logic [4*N-1:0] t;
        t = '0;
        for (int i = 0; i < N; i++) t = {lim_m[i], t[4*N-1:4]};
        limit = t;
    endtask

    task automatic step();
        @(posedge clock);
        n++;
        #1;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_gnt"},   32'(gnt),        32'(0));
        chk({tag, "_valid"}, 32'(valid),      32'(0));
        chk({tag, "_busy"},  32'(busy),       32'(0));
        chk({tag, "_rand"},  32'(random_out), 32'(exp_rand));
    endtask

    task automatic release_reset();
        reset    = 1'b0;
        n        = 0;
        mptr     = 0;
        exp_rand = 4'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        exp_rand = 4'h0;
        check_quiet("rst_async");
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
    endtask

    // One full service starting with the next edge in IDLE.
    // mode 0: limits untouched; 1: randomise all limits after grant;
    // 2: force lim_m[0]=1 after grant.
    task automatic serve(input int mode);
        int idx;
        int lv;
        int e;
        int guard;
        idx = rr_pick(req, mptr);
        lv  = (lim_m[idx] == 4'h0) ? 16 : int'(lim_m[idx]);
        step();
        chk("grant_gnt",   32'(gnt),   32'(onehot(idx)));
        chk("grant_busy",  32'(busy),  32'(1));
        chk("grant_valid", 32'(valid), 32'(0));
        e = n + 1;
        while (int'(seq[(e - 1) % 15]) >= lv) e++;
        if (mode == 1) begin
            for (int i = 0; i < N; i++) lim_m[i] = 4'($urandom_range(0, 15));
            drive_limits();
        end else if (mode == 2) begin
            lim_m[0] = 4'h1;
            drive_limits();
        end
        guard = 0;
        while (n < e && guard < 20) begin
            step();
            guard++;
            if (n < e) begin
                chk("serve_valid", 32'(valid),      32'(0));
                chk("serve_gnt",   32'(gnt),        32'(onehot(idx)));
                chk("serve_hold",  32'(random_out), 32'(exp_rand));
            end
        end
        exp_rand = seq[(e - 1) % 15];
        chk("accept_valid", 32'(valid),      32'(1));
        chk("accept_value", 32'(random_out), 32'(exp_rand));
        chk("accept_gnt",   32'(gnt),        32'(onehot(idx)));
        chk("accept_busy",  32'(busy),       32'(1));
        req  = req & ~onehot(idx);
        mptr = (idx + 1) % N;
        step();
        check_quiet("done");
    endtask

    initial begin
        for (int i = 0; i < N; i++) lim_m[i] = 4'h0;
        drive_limits();
        repeat (2) @(posedge clock);
        #1;
        check_quiet("reset");

        // Unbounded request: first sample 1 accepted two edges after release.
        req = 4'b0001;
        release_reset();
        serve(0);
        step();
        check_quiet("idle");

        // Limit 1: only 0 is accepted, which arrives on edge 16.
        do_reset();
        req = 4'b0001;
        lim_m[0] = 4'h1;
        drive_limits();
        release_reset();
        serve(0);

        // All four requesting: order 0,1,2,3 then pointer wraps.
        do_reset();
        for (int i = 0; i < N; i++) lim_m[i] = 4'h0;
        drive_limits();
        req = 4'b1111;
        release_reset();
        repeat (4) serve(0);
        req = 4'b0010;
        serve(0);
        req = 4'b1010;
        serve(0);
        serve(0);

        // Reset mid-SERVE: outputs clear at once and no valid follows.
        do_reset();
        req = 4'b0001;
        lim_m[0] = 4'h1;
        drive_limits();
        release_reset();
        step();
        chk("mid_grant", 32'(gnt), 32'(onehot(0)));
        repeat (3) step();
        reset = 1'b1;
        #1;
        check_quiet("mid_reset");
        req = '0;
        @(posedge clock);
        #1;
        check_quiet("mid_hold");
        req = 4'b0001;
        lim_m[0] = 4'h0;
        drive_limits();
        release_reset();
        serve(0);

        // Limit changed during SERVE is ignored.
        do_reset();
        req = 4'b0001;
        lim_m[0] = 4'h3;
        drive_limits();
        release_reset();
        serve(2);
        chk("latched_lt3", 32'(random_out < 4'h3), 32'(1));

        // Randomised traffic.
        for (int it = 0; it < 40; it++) begin
            req = req | N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < N; i++) lim_m[i] = 4'($urandom_range(0, 15));
                drive_limits();
            end
            if (req == '0) begin
                step();
                check_quiet("rnd_idle");
            end else begin
                serve(int'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
